// File: rtl/sm_clk_ctrl.sv
// sm_clk_ctrl: programmable clock generator (clk / 2^(SHIFT+devide+1)) with glitch-free divider
// change, halt/run/single-step control and a per-period tick. Define SM_CLK_CTRL_CYCLES_EN to add the cycles counter port.
module sm_clk_ctrl #(
  parameter int SHIFT      = 16,
  parameter int DIV_W      = 4,
  parameter int DEB_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] devide,
  input  logic             enable,
  input  logic             stepBtn,
  output logic             clkOut,
  output logic             tick
`ifdef SM_CLK_CTRL_CYCLES_EN
  ,
  output logic [31:0]      cycles
`endif
);

  localparam int CNT_W = SHIFT + (1 << DIV_W);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  logic [DIV_W-1:0]      r_div_sync [DEB_STAGES];
  logic [DEB_STAGES-1:0] r_en_sync;
  logic [DEB_STAGES-1:0] r_step_sync;
  logic                  r_step_d;
  logic                  r_step_edge;

  state_t                r_state;
  logic                  r_clk;
  logic                  r_tick;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIV_W-1:0]      r_div;

  logic [DIV_W-1:0]      w_div_s;
  logic                  w_en_s;
  logic                  w_step_s;
  logic [CNT_W-1:0]      w_half_m1;
  logic                  w_half_end;
  logic                  w_period_end;

  assign w_div_s  = r_div_sync[DEB_STAGES-1];
  assign w_en_s   = r_en_sync[DEB_STAGES-1];
  assign w_step_s = r_step_sync[DEB_STAGES-1];

  // Board switches change rarely; the multi-bit devide bus is only consumed at period start.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the synchroniser array is control state, so it is explicitly cleared on reset.
      for (int i = 0; i < DEB_STAGES; i++) begin
        r_div_sync[i] <= '0;
      end
      r_en_sync   <= '0;
      r_step_sync <= '0;
      r_step_d    <= 1'b0;
      r_step_edge <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop in the chain sample its pre-edge input.
      r_div_sync[0] <= devide;
      for (int i = 1; i < DEB_STAGES; i++) begin
        r_div_sync[i] <= r_div_sync[i-1];
      end
      r_en_sync   <= {r_en_sync[DEB_STAGES-2:0], enable};
      r_step_sync <= {r_step_sync[DEB_STAGES-2:0], stepBtn};
      r_step_d    <= w_step_s;
      r_step_edge <= w_step_s & ~r_step_d;
    end
  end

  assign w_half_m1    = (CNT_W'(1) << (SHIFT + int'(r_div))) - CNT_W'(1);
  assign w_half_end   = (r_cnt == w_half_m1);
  assign w_period_end = (r_state != S_HALT) && w_half_end && !r_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HALT;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
      r_cnt   <= '0;
      r_div   <= '0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        S_HALT: begin
          r_cnt <= '0;
          r_clk <= 1'b0;
          if (w_en_s || r_step_edge) begin
            r_state <= w_en_s ? S_RUN : S_STEP;
            r_clk   <= 1'b1;
            r_tick  <= 1'b1;
            r_div   <= w_div_s;
          end
        end
        S_RUN, S_STEP: begin
          if (!w_half_end) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= '0;
            if (r_clk) begin
              r_clk <= 1'b0;
            end else if (r_state == S_RUN && w_en_s) begin
              // Back-to-back period: the new divider is picked up only here.
              r_clk  <= 1'b1;
              r_tick <= 1'b1;
              r_div  <= w_div_s;
            end else begin
              r_state <= S_HALT;
            end
          end
        end
        default: begin
          r_state <= S_HALT;
          r_clk   <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign clkOut = r_clk;
  assign tick   = r_tick;

`ifdef SM_CLK_CTRL_CYCLES_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles <= '0;
    end else if (w_period_end) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign cycles = r_cycles;
`endif

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Self-checking bench for sm_clk_ctrl: directed scenarios plus random stimulus, all compared
// every cycle against a period-scheduling reference model.
module tb_sm_clk_ctrl;

  localparam int SHIFT = 0;
  localparam int DIV_W = 4;
  localparam int DEB   = 2;
  localparam int MAXC  = 16384;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] devide;
  logic             enable;
  logic             step_btn;
  logic             clk_out;
  logic             tick;
`ifdef SM_CLK_CTRL_CYCLES_EN
  logic [31:0]      cycles;
`endif

  always #5 clk = ~clk;

  sm_clk_ctrl #(
    .SHIFT      (SHIFT),
    .DIV_W      (DIV_W),
    .DEB_STAGES (DEB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .devide  (devide),
    .enable  (enable),
    .stepBtn (step_btn),
    .clkOut  (clk_out),
    .tick    (tick)
`ifdef SM_CLK_CTRL_CYCLES_EN
    ,
    .cycles  (cycles)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Input history indexed by clock edge; anything at or before the last reset edge reads as 0.
  logic             en_h [MAXC];
  logic             st_h [MAXC];
  logic [DIV_W-1:0] dv_h [MAXC];
  int               k        = 0;
  int               last_rst = -1;

  // Model: either idle, or inside a period that started at edge m_start with half length m_half.
  bit          m_active = 0;
  bit          m_step   = 0;
  int          m_start  = 0;
  int          m_half   = 1;
  bit          m_clk    = 0;
  bit          m_tick   = 0;
  logic [31:0] m_cycles = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic h_en(input int idx);
    return (idx <= last_rst) ? 1'b0 : en_h[idx];
  endfunction

  function automatic logic h_st(input int idx);
    return (idx <= last_rst) ? 1'b0 : st_h[idx];
  endfunction

  function automatic logic [DIV_W-1:0] h_dv(input int idx);
    return (idx <= last_rst) ? '0 : dv_h[idx];
  endfunction

  task automatic start_period(input logic [DIV_W-1:0] div, input bit is_step);
    m_active = 1;
    m_step   = is_step;
    m_start  = k;
    m_half   = 1 << (SHIFT + int'(div));
    m_tick   = 1;
  endtask

  // Called right after a posedge with the input values the DUT just sampled.
  task automatic model_step();
    logic             en_s;
    logic             step_edge;
    logic [DIV_W-1:0] div_s;
    en_h[k] = enable;
    st_h[k] = step_btn;
    dv_h[k] = devide;
    if (rst) begin
      last_rst = k;
      m_active = 0;
      m_clk    = 0;
      m_tick   = 0;
      m_cycles = '0;
    end else begin
      en_s      = h_en(k - DEB);
      div_s     = h_dv(k - DEB);
      step_edge = h_st(k - DEB - 1) & ~h_st(k - DEB - 2);
      m_tick    = 0;
      if (m_active && (k - m_start == 2 * m_half)) begin
        m_cycles = m_cycles + 32'd1;
        if (!m_step && en_s) start_period(div_s, 0);
        else m_active = 0;
      end else if (!m_active) begin
        if (en_s) start_period(div_s, 0);
        else if (step_edge) start_period(div_s, 1);
      end
      m_clk = m_active && (k - m_start < m_half);
    end
    k++;
  endtask

  task automatic compare();
    check("clkOut", 32'(clk_out), 32'(m_clk));
    check("tick", 32'(tick), 32'(m_tick));
`ifdef SM_CLK_CTRL_CYCLES_EN
    check("cycles", cycles, m_cycles);
`endif
  endtask

  task automatic step_cyc();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step_cyc();
      n++;
    end while (tick !== 1'b1 && n < 300);
    if (n >= 300) check("tick_timeout", 32'(tick), 32'd1);
  endtask

  initial begin
    int n;
    int highs;
    int ticks;
    logic [7:0] pat_dut;
    logic [7:0] pat_mdl;

    rst = 1'b1; enable = 1'b1; devide = 4'd2; step_btn = 1'b0;

    // Reset with enable already high.
    for (int i = 0; i < 3; i++) begin
      step_cyc();
      check("rst_clkOut", 32'(clk_out), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
    end
    rst = 1'b0;
    step_cyc(); check("rel1_clkOut", 32'(clk_out), 32'd0);
    step_cyc(); check("rel2_clkOut", 32'(clk_out), 32'd0);
    step_cyc();
    check("rel3_clkOut", 32'(clk_out), 32'd1);
    check("rel3_tick", 32'(tick), 32'd1);
    check("rel3_model_clk", 32'(m_clk), 32'd1);

    // Free run at devide=2: 4 high / 4 low.
    pat_dut = {7'd0, clk_out};
    pat_mdl = {7'd0, m_clk};
    for (int i = 0; i < 7; i++) begin
      step_cyc();
      pat_dut = {pat_dut[6:0], clk_out};
      pat_mdl = {pat_mdl[6:0], m_clk};
    end
    check("div2_pattern", 32'(pat_dut), 32'hF0);
    check("div2_model_pattern", 32'(pat_mdl), 32'hF0);
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      step_cyc();
      if (tick === 1'b1) ticks++;
    end
    check("div2_ticks16", 32'(ticks), 32'd2);

    // devide 2->0 during a high half.
    wait_tick(n);
    devide = 4'd0;
    wait_tick(n); check("chg_period_old", 32'(n), 32'd8);
    wait_tick(n); check("chg_period_new1", 32'(n), 32'd2);
    wait_tick(n); check("chg_period_new2", 32'(n), 32'd2);

    // enable 1->0 during a high half at devide=2.
    devide = 4'd2;
    wait_tick(n);
    wait_tick(n);
    wait_tick(n); check("stop_pre_period", 32'(n), 32'd8);
    enable = 1'b0;
    highs = 0; ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step_cyc();
      if (clk_out === 1'b1) highs++;
      if (tick === 1'b1) ticks++;
    end
    check("stop_rest_high", 32'(highs), 32'd3);
    check("stop_ticks", 32'(ticks), 32'd0);

    // Single step at devide=1, with a second press inside the stepped period.
    devide = 4'd1;
    for (int i = 0; i < 4; i++) step_cyc();
    highs = 0; ticks = 0;
    for (int i = 0; i < 36; i++) begin
      step_btn = (i < 3 || i == 4) ? 1'b1 : 1'b0;
      step_cyc();
      if (clk_out === 1'b1) highs++;
      if (tick === 1'b1) ticks++;
    end
    check("step_high", 32'(highs), 32'd2);
    check("step_ticks", 32'(ticks), 32'd1);

    // Completed-period counting: 5 run periods then one step.
    rst = 1'b1; enable = 1'b1; devide = 4'd1;
    step_cyc();
`ifdef SM_CLK_CTRL_CYCLES_EN
    check("cnt_rst0", cycles, 32'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 5; i++) wait_tick(n);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) step_cyc();
    check("cnt_run_model", m_cycles, 32'd5);
`ifdef SM_CLK_CTRL_CYCLES_EN
    check("cnt_run", cycles, 32'd5);
`endif
    step_btn = 1'b1; step_cyc(); step_cyc();
    step_btn = 1'b0;
    for (int i = 0; i < 20; i++) step_cyc();
    check("cnt_step_model", m_cycles, 32'd6);
`ifdef SM_CLK_CTRL_CYCLES_EN
    check("cnt_step", cycles, 32'd6);
`endif
    rst = 1'b1; step_cyc(); rst = 1'b0;
`ifdef SM_CLK_CTRL_CYCLES_EN
    check("cnt_rst1", cycles, 32'd0);
`endif

    // Random stimulus.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) enable = ~enable;
      if ($urandom_range(29) == 0) devide = 4'($urandom_range(3));
      if ($urandom_range(9) == 0) step_btn = ~step_btn;
      rst = ($urandom_range(499) == 0);
      step_cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
